// File: rtl/mtrx_slice_fifo_ctrl.sv
// Round-robin burst arbiter in front of a 64b-in/8b-out slice FIFO, plus a
// 2-entry skid on the read side that presents the FIFO as a valid/ready byte stream.
module mtrx_slice_fifo_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_WORDS  = 32,
  parameter int SLICE_BYTES = 64
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic [NUM_REQ-1:0]    wvalid,
  input  logic [NUM_REQ*64-1:0] wdata,
  output logic [63:0]           fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_dout,
  input  logic                  fifo_empty,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  slice_done,
  output logic                  ovf_err
);

  localparam int CAP    = FIFO_WORDS * 8;
  localparam int OCC_W  = $clog2(CAP) + 1;
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SL_W   = (SLICE_BYTES > 1) ? $clog2(SLICE_BYTES) : 1;
  localparam logic [OCC_W-1:0] L_CAP   = OCC_W'(CAP);
  localparam logic [OCC_W-1:0] L_BURST = OCC_W'(BURST_LEN * 8);
  localparam logic [OCC_W-1:0] L_WORD  = OCC_W'(8);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                     r_state, w_state_n;
  logic [NUM_REQ-1:0]         r_gnt;
  logic [PTR_W-1:0]           r_gidx, r_rr, w_pick_idx;
  logic [PTR_W:0]             w_scan;
  logic [BEAT_W-1:0]          r_beat_cnt;
  logic [NUM_REQ-1:0][63:0]   w_wd;
  logic [63:0]                r_din;
  logic                       r_wr_en;
  logic [OCC_W-1:0]           r_used, r_resv, w_free;
  logic                       w_can_grant, w_grant, w_beat, w_last;
  logic [1:0][7:0]            r_skid;
  logic [1:0]                 r_skid_cnt;
  logic                       r_inflight, w_pop, w_rd_en;
  logic [2:0]                 w_room;
  logic [SL_W-1:0]            r_slice_cnt;
  logic                       r_slice_done, r_ovf;

  assign w_wd = wdata;

  // Occupancy is split into bytes really in the FIFO and bytes promised to the
  // burst in flight, so a new grant can never overcommit the FIFO.
  assign w_free      = L_CAP - r_used - r_resv;
  assign w_can_grant = (|req) && (w_free >= L_BURST);
  assign w_grant     = (r_state == ST_IDLE) && w_can_grant;
  assign w_beat      = (r_state == ST_BURST) && wvalid[r_gidx];
  assign w_last      = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));

  // Scan downwards so the requester closest to r_rr is the last one written.
  always_comb begin
    w_pick_idx = '0;
    w_scan     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr} + (PTR_W+1)'(k);
      if (w_scan >= (PTR_W+1)'(NUM_REQ)) w_scan = w_scan - (PTR_W+1)'(NUM_REQ);
      if (req[w_scan[PTR_W-1:0]]) w_pick_idx = w_scan[PTR_W-1:0];
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:  if (w_can_grant) w_state_n = ST_BURST;
      ST_BURST: if (w_beat && w_last) w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_rr       <= '0;
      r_beat_cnt <= '0;
    end else if (w_grant) begin
      r_gnt  <= NUM_REQ'(1) << w_pick_idx;
      r_gidx <= w_pick_idx;
    end else if (w_beat) begin
      if (w_last) begin
        r_gnt      <= '0;
        r_beat_cnt <= '0;
        r_rr       <= (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_wr_en <= 1'b0;
      r_din   <= '0;
      r_used  <= '0;
      r_resv  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr_en <= w_beat;
      if (w_beat) r_din <= w_wd[r_gidx];
      r_used  <= r_used + (r_wr_en ? L_WORD : '0) - (w_rd_en ? OCC_W'(1) : '0);
      r_resv  <= r_resv + (w_grant ? L_BURST : '0) - (r_wr_en ? L_WORD : '0);
      if (r_wr_en && fifo_full) r_ovf <= 1'b1;
    end
  end

  // Read side: keep skid entries plus the byte still in the FIFO pipe at <= 2.
  assign w_pop   = (r_skid_cnt != 2'd0) && byte_ready;
  assign w_room  = {1'b0, r_skid_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rd_en = s_rst && !fifo_empty && (w_room < 3'd2);

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_inflight <= 1'b0;
      r_skid     <= '0;
      r_skid_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;
      case ({r_inflight, w_pop})
        2'b01: begin
          r_skid[0]  <= r_skid[1];
          r_skid_cnt <= r_skid_cnt - 1'b1;
        end
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid[0] <= fifo_dout;
          else                    r_skid[1] <= fifo_dout;
          r_skid_cnt <= r_skid_cnt + 1'b1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid[0] <= fifo_dout;
          end else begin
            r_skid[0] <= r_skid[1];
            r_skid[1] <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_slice_cnt  <= '0;
      r_slice_done <= 1'b0;
    end else begin
      r_slice_done <= w_pop && (r_slice_cnt == SL_W'(SLICE_BYTES - 1));
      if (w_pop)
        r_slice_cnt <= (r_slice_cnt == SL_W'(SLICE_BYTES - 1)) ? '0 : r_slice_cnt + 1'b1;
    end
  end

  assign gnt        = r_gnt;
  assign fifo_din   = r_din;
  assign fifo_wr_en = r_wr_en;
  assign fifo_rd_en = w_rd_en;
  assign byte_data  = r_skid[0];
  assign byte_valid = (r_skid_cnt != 2'd0);
  assign slice_done = r_slice_done;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_mtrx_slice_fifo_ctrl.sv
// Bench for mtrx_slice_fifo_ctrl: behavioural FIFO, transaction-level arbiter /
// credit / byte-stream model, a vector table for arbitration and hand sequences for corners.
module tb_mtrx_slice_fifo_ctrl;
  localparam int NR = 4, BL = 8, FW = 32, SB = 64;
  localparam int CAP = FW * 8, BB = BL * 8;

  logic s_clk = 1'b0, s_rst = 1'b0;
  logic [NR-1:0] req, gnt, wvalid;
  logic [NR*64-1:0] wdata;
  logic [63:0] fifo_din;
  logic fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [7:0] fifo_dout, byte_data;
  logic byte_valid, byte_ready, slice_done, ovf_err;

  logic a_req[NR];
  logic a_wv[NR];
  logic [63:0] a_wd[NR];
  int rdy_mode;
  bit force_full, chk_en;

  always #5 s_clk = ~s_clk;

  always_comb begin
    req = '0; wvalid = '0; wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req[i] = a_req[i];
      wvalid[i] = a_wv[i];
      wdata[64*i +: 64] = a_wd[i];
    end
  end

  mtrx_slice_fifo_ctrl #(.NUM_REQ(NR), .BURST_LEN(BL), .FIFO_WORDS(FW), .SLICE_BYTES(SB)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .req(req), .gnt(gnt), .wvalid(wvalid), .wdata(wdata),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .slice_done(slice_done), .ovf_err(ovf_err));

  // Behavioural FIFO: 64b in, MSB byte first out, flushed by reset.
  logic [7:0] fq[$];
  int fcnt;
  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt > CAP - 8) || force_full;
  always @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      fq.delete();
      fifo_dout <= '0;
      fcnt <= 0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (fifo_wr_en && !fifo_full)
        for (int b = 7; b >= 0; b--) fq.push_back(fifo_din[8*b +: 8]);
      fcnt <= fq.size();
    end
  end

  initial begin
    byte_ready = 1'b0;
    forever begin
      @(posedge s_clk); #1;
      case (rdy_mode)
        0: byte_ready = 1'b0;
        1: byte_ready = 1'b1;
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int n_pass = 0, n_tot = 0;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int pick(logic [NR-1:0] r, int rr);
    for (int k = 0; k < NR; k++) if (r[(rr + k) % NR]) return (rr + k) % NR;
    return -1;
  endfunction

  function automatic int oh_idx(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model state, advanced once per cycle at the falling edge.
  logic [NR-1:0] m_exp_gnt, prev_gnt;
  int m_rr, m_beats, m_occ, m_reads, m_pops, m_popcnt, n_slice, n_rise;
  bit m_sd_pend, m_wr_pend, m_stall;
  logic [63:0] m_wr_din;
  logic [7:0] m_stall_data;
  logic [7:0] m_bytes[$];
  logic [7:0] got[$];
  int order[$];

  always @(negedge s_clk) begin
    if (!s_rst) begin
      m_exp_gnt = '0; prev_gnt = '0; m_rr = 0; m_beats = 0; m_occ = 0;
      m_reads = 0; m_pops = 0; m_popcnt = 0; m_sd_pend = 0; m_wr_pend = 0; m_stall = 0;
      n_rise = 0; m_bytes.delete(); order.delete();
    end else if (chk_en) begin
      automatic bit pop = byte_valid && byte_ready;
      automatic int p;
      check("gnt", gnt, m_exp_gnt);
      check("fifo_wr_en", fifo_wr_en, m_wr_pend);
      if (m_wr_pend) check("fifo_din", fifo_din, m_wr_din);
      check("slice_done", slice_done, m_sd_pend);
      check("ovf_err", ovf_err, 0);
      check("occ_bound", m_occ <= CAP, 1);
      check("buffered_le2", (m_reads - m_pops) <= 2, 1);
      if (fifo_rd_en) check("rd_when_empty", fifo_empty, 0);
      if (m_stall) begin
        check("hold_valid", byte_valid, 1);
        check("hold_data", byte_data, m_stall_data);
      end
      if (slice_done) n_slice++;
      if (prev_gnt == 0 && gnt != 0) begin n_rise++; order.push_back(oh_idx(gnt)); end
      prev_gnt = gnt;
      if (pop) begin
        got.push_back(byte_data);
        check("byte_expected", m_bytes.size() > 0, 1);
        if (m_bytes.size() > 0) check("byte_data", byte_data, m_bytes.pop_front());
      end
      m_sd_pend = pop && ((m_popcnt + 1) % SB == 0);
      if (pop) begin m_popcnt++; m_pops++; end
      m_stall = byte_valid && !byte_ready;
      m_stall_data = byte_data;
      if (m_exp_gnt != 0) begin
        p = oh_idx(m_exp_gnt);
        m_wr_pend = a_wv[p];
        if (a_wv[p]) begin
          m_wr_din = a_wd[p];
          for (int b = 7; b >= 0; b--) m_bytes.push_back(a_wd[p][8*b +: 8]);
          m_beats++;
          if (m_beats == BL) begin m_exp_gnt = '0; m_rr = (p + 1) % NR; m_beats = 0; end
        end
      end else begin
        m_wr_pend = 0;
        p = pick(req, m_rr);
        if (p >= 0 && CAP - m_occ >= BB) begin m_exp_gnt = NR'(1) << p; m_occ += BB; end
      end
      if (fifo_rd_en) begin m_occ--; m_reads++; end
    end
  end

  task automatic writer(int p, int nb, bit toggle, bit fixed, logic [63:0] fdat);
    for (int b = 0; b < nb; b++) begin
      int beats = 0, cyc = 0;
      bit act;
      a_req[p] = 1'b1;
      while (beats < BL) begin
        a_wd[p] = fixed ? fdat : {$urandom, $urandom};
        a_wv[p] = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        act = gnt[p];
        @(posedge s_clk); #1;
        if (act && a_wv[p]) beats++;
        cyc++;
        if (cyc > 3000) begin check("writer_timeout", beats, BL); break; end
      end
      a_req[p] = 1'b0;
      a_wv[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge s_clk); #2;
    s_rst = 1'b0;
    repeat (3) @(posedge s_clk);
    #1 s_rst = 1'b1;
  endtask

  task automatic wait_drain(string nm);
    int cyc = 0;
    while (m_bytes.size() > 0 && cyc < 2000) begin @(posedge s_clk); #1; cyc++; end
    repeat (4) @(posedge s_clk); #1;
    check(nm, m_bytes.size(), 0);
  endtask

  task automatic single_burst_check(string tag);
    got.delete();
    n_slice = 0;
    writer(0, 1, 0, 1, 64'h0000_0000_1234_5678);
    repeat (100) @(posedge s_clk); #1;
    check({tag, "_nbytes"}, got.size(), 64);
    if (got.size() == 64) begin
      check({tag, "_b0"}, got[0], 8'h00);
      check({tag, "_b4"}, got[4], 8'h12);
      check({tag, "_b7"}, got[7], 8'h78);
      check({tag, "_b63"}, got[63], 8'h78);
    end
    check({tag, "_slices"}, n_slice, 1);
  endtask

  typedef struct { logic [NR-1:0] rq; logic [NR-1:0] exp_gnt; } vec_t;
  vec_t tv[6];
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{4'b0100, 4'b0100};
    tv[1] = '{4'b0011, 4'b0001};
    tv[2] = '{4'b1001, 4'b1000};
    tv[3] = '{4'b0110, 4'b0010};
    tv[4] = '{4'b1010, 4'b1000};
    tv[5] = '{4'b1111, 4'b0001};
    for (int i = 0; i < NR; i++) begin a_req[i] = 0; a_wv[i] = 0; a_wd[i] = '0; end
    rdy_mode = 1; force_full = 0; chk_en = 1;

    // T1 reset values
    #200;
    check("rst_gnt", gnt, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_slice_done", slice_done, 0);
    @(posedge s_clk); #1 s_rst = 1'b1;

    // Round-robin vector table, starting from pointer 0
    for (int v = 0; v < 6; v++) begin
      int cyc = 0, p;
      for (int i = 0; i < NR; i++) a_req[i] = tv[v].rq[i];
      while (gnt == 0 && cyc < 200) begin @(posedge s_clk); #1; cyc++; end
      check($sformatf("tv%0d_gnt", v), gnt, tv[v].exp_gnt);
      p = oh_idx(gnt);
      for (int i = 0; i < NR; i++) a_req[i] = 0;
      if (p >= 0) begin
        for (int b = 0; b < BL; b++) begin
          a_wv[p] = 1'b1; a_wd[p] = {$urandom, $urandom};
          @(posedge s_clk); #1;
        end
        a_wv[p] = 1'b0;
      end
      repeat (2) @(posedge s_clk); #1;
    end
    wait_drain("tv_drain");

    // T2 single burst with known data
    single_burst_check("t2");

    // T3 all requesting, reader stalled: four grants then stall on credits
    do_reset();
    rdy_mode = 0;
    fork
      writer(0, 2, 0, 0, '0);
      writer(1, 1, 0, 0, '0);
      writer(2, 1, 0, 0, '0);
      writer(3, 1, 0, 0, '0);
      begin
        repeat (150) @(posedge s_clk); #1;
        check("t3_grants_stalled", n_rise, 4);
        check("t3_gnt_idle", gnt, 0);
        rdy_mode = 1;
      end
    join
    check("t3_order_len", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("t3_order%0d", i), order[i], exp_ord[i]);
    wait_drain("t3_drain");

    // T4 random stalls on both sides
    rdy_mode = 2;
    fork
      writer(0, 3, 1, 0, '0);
      writer(1, 3, 1, 0, '0);
      writer(2, 3, 1, 0, '0);
      writer(3, 3, 1, 0, '0);
    join
    rdy_mode = 1;
    wait_drain("t4_drain");

    // T6 reset after three beats of a burst
    do_reset();
    begin
      int cyc = 0, beats = 0;
      a_req[0] = 1'b1;
      while (beats < 3 && cyc < 100) begin
        bit act;
        a_wv[0] = 1'b1; a_wd[0] = {$urandom, $urandom};
        act = gnt[0];
        @(posedge s_clk); #1;
        if (act) beats++;
        cyc++;
      end
      check("t6_beats", beats, 3);
      #1 s_rst = 1'b0;
      #1;
      check("t6_gnt", gnt, 0);
      check("t6_wr_en", fifo_wr_en, 0);
      check("t6_rd_en", fifo_rd_en, 0);
      check("t6_byte_valid", byte_valid, 0);
      check("t6_slice_done", slice_done, 0);
      check("t6_ovf", ovf_err, 0);
      a_req[0] = 1'b0; a_wv[0] = 1'b0;
      repeat (3) @(posedge s_clk);
      #1 s_rst = 1'b1;
    end
    single_burst_check("t6_t2");

    // Overflow flag: write while FIFO claims full, sticky until reset
    chk_en = 0;
    force_full = 1;
    writer(1, 1, 0, 0, '0);
    repeat (2) @(posedge s_clk); #1;
    check("ovf_set", ovf_err, 1);
    force_full = 0;
    repeat (3) @(posedge s_clk); #1;
    check("ovf_sticky", ovf_err, 1);
    do_reset();
    check("ovf_clear", ovf_err, 0);
    chk_en = 1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
